spi_transfer_controller: RTL and testbench

Transfer sequencer for the APB-interfaced SPI master core. It sits between the APB slave register block and the SPI pins. It takes the configuration (mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode) and the send_data/mosi_data request from the register block. It generates the baud-rate-divided sclk, drives ss and mosi, samples miso, and returns received bytes via receive_data/miso_data. It owns the transfer state machine and the tip (transfer-in-progress) flag.

---
 rtl/spi_transfer_controller.sv | 205 ++++++++++++++++++++
 tb/tb_spi_transfer_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_controller.sv
// SPI master transfer sequencer: baud-divided sclk, ss/mosi drive, miso capture
// and the transfer-in-progress flag, sitting between the APB register block and the pins.
module spi_transfer_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             mstr,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsbfe,
  input  logic [2:0]       sppr,
  input  logic [2:0]       spr,
  input  logic [1:0]       spi_mode,
  input  logic             send_data,
  input  logic [WIDTH-1:0] mosi_data,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             ss,
  output logic             tip,
  output logic             receive_data,
  output logic [WIDTH-1:0] miso_data
);

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned EDGE_W = $clog2(2 * WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hm1_q, hm1_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   miso_data_q, miso_data_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               lsbfe_q, lsbfe_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               ss_q, ss_d;
  logic               tip_q, tip_d;
  logic               rd_q, rd_d;

  logic [CNT_W-1:0]   half_c;
  logic [CNT_W-1:0]   hm1_c;
  logic               start_c;
  logic               stop_c;
  logic               leading_c;
  logic               sample_c;
  logic               advance_c;

  // Half-period H = D/2 = (sppr+1) << spr; the counter compares against H-1.
  assign half_c  = (CNT_W'(sppr) + CNT_W'(1)) << spr;
  assign hm1_c   = half_c - CNT_W'(1);
  assign start_c = send_data && mstr && (spi_mode == 2'b00);
  assign stop_c  = (spi_mode == 2'b10);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hm1_q       <= '0;
      edge_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      tip_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hm1_q       <= hm1_d;
      edge_q      <= edge_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsbfe_q     <= lsbfe_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      tip_q       <= tip_d;
      rd_q        <= rd_d;
    end
  end

  // Next-state and registered-output logic; abort (mstr=0) takes priority over stop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hm1_d       = hm1_q;
    edge_d      = edge_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsbfe_d     = lsbfe_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    tip_d       = tip_q;
    rd_d        = 1'b0;
    leading_c   = 1'b0;
    sample_c    = 1'b0;
    advance_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        edge_d = '0;
        sclk_d = cpol;
        ss_d   = 1'b1;
        tip_d  = 1'b0;
        if (start_c) begin
          state_d = ST_LOAD;
          tx_d    = mosi_data;
          rx_d    = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsbfe_d = lsbfe;
          hm1_d   = hm1_c;
          ss_d    = 1'b0;
          tip_d   = 1'b1;
          mosi_d  = lsbfe ? mosi_data[0] : mosi_data[WIDTH-1];
        end
      end

      ST_LOAD: begin
        if (!mstr) begin
          state_d = ST_IDLE;
          ss_d    = 1'b1;
          tip_d   = 1'b0;
          sclk_d  = cpol;
        end else if (!stop_c) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (!mstr) begin
          state_d = ST_IDLE;
          ss_d    = 1'b1;
          tip_d   = 1'b0;
          sclk_d  = cpol;
        end else if (!stop_c) begin
          if (cnt_q == hm1_q) begin
            cnt_d     = '0;
            sclk_d    = ~sclk_q;
            edge_d    = edge_q + EDGE_W'(1);
            leading_c = edge_d[0];
            sample_c  = cpha_q ? !leading_c : leading_c;
            advance_c = cpha_q ? (leading_c && (edge_d != EDGE_W'(1))) : !leading_c;
            if (sample_c) begin
              rx_d = lsbfe_q ? {miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso};
            end
            if (advance_c) begin
              tx_d   = lsbfe_q ? (tx_q >> 1) : (tx_q << 1);
              mosi_d = lsbfe_q ? tx_d[0] : tx_d[WIDTH-1];
            end
            if (edge_d == EDGE_W'(2 * WIDTH)) begin
              state_d     = ST_DONE;
              ss_d        = 1'b1;
              tip_d       = 1'b0;
              rd_d        = 1'b1;
              miso_data_d = rx_d;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        sclk_d  = cpol;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss           = ss_q;
  assign tip          = tip_q;
  assign receive_data = rd_q;
  assign miso_data    = miso_data_q;

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Bench for spi_transfer_controller: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_spi_transfer_controller;

  localparam int unsigned WIDTH = 8;

  logic             PCLK;
  logic             PRESETn;
  logic             mstr;
  logic             cpol;
  logic             cpha;
  logic             lsbfe;
  logic [2:0]       sppr;
  logic [2:0]       spr;
  logic [1:0]       spi_mode;
  logic             send_data;
  logic [WIDTH-1:0] mosi_data;
  logic             miso;
  logic             sclk;
  logic             mosi;
  logic             ss;
  logic             tip;
  logic             receive_data;
  logic [WIDTH-1:0] miso_data;

  logic             loop_en;
  logic [WIDTH-1:0] slave_byte;
  logic             slv_bit;
  logic             chk_en;
  int               errors;
  int               checks;

  spi_transfer_controller #(.WIDTH(WIDTH)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .mstr         (mstr),
    .cpol         (cpol),
    .cpha         (cpha),
    .lsbfe        (lsbfe),
    .sppr         (sppr),
    .spr          (spr),
    .spi_mode     (spi_mode),
    .send_data    (send_data),
    .mosi_data    (mosi_data),
    .miso         (miso),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .tip          (tip),
    .receive_data (receive_data),
    .miso_data    (miso_data)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign miso = loop_en ? mosi : slv_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #2;
    end
  endtask

  // Frame-level model: progress p counts un-stopped XFER cycles; edges = p / H.
  typedef enum int {M_IDLE, M_LOAD, M_XFER, M_DONE} mph_t;
  mph_t             ph;
  int               p, f_h, m_e, m_idx;
  logic             f_cpol, f_cpha, f_lsb;
  logic [WIDTH-1:0] f_data, f_exp, e_md;
  logic             e_sclk, e_mosi, mosi_known;

  initial begin
    ph = M_IDLE; p = 0; f_h = 1; f_cpol = 1'b0; f_cpha = 1'b0; f_lsb = 1'b0;
    f_data = '0; f_exp = '0; e_md = '0; e_sclk = 1'b0; e_mosi = 1'b0; mosi_known = 1'b0;
    m_e = 0; m_idx = 0;
    forever begin
      @(posedge PCLK);
      if (!PRESETn) begin
        ph = M_IDLE; e_sclk = 1'b0; e_mosi = 1'b0; e_md = '0; mosi_known = 1'b1;
      end else begin
        case (ph)
          M_IDLE: begin
            e_sclk = cpol;
            if (send_data && mstr && spi_mode == 2'b00) begin
              ph = M_LOAD; p = 0;
              f_cpol = cpol; f_cpha = cpha; f_lsb = lsbfe;
              f_h = ((int'(sppr) + 1) << (int'(spr) + 1)) / 2;
              f_data = mosi_data;
              f_exp = loop_en ? mosi_data : slave_byte;
              mosi_known = 1'b1;
            end
          end
          M_LOAD: begin
            if (!mstr) begin
              ph = M_IDLE; e_sclk = cpol; mosi_known = 1'b0;
            end else if (spi_mode != 2'b10) begin
              ph = M_XFER; p = 0;
            end
          end
          M_XFER: begin
            if (!mstr) begin
              ph = M_IDLE; e_sclk = cpol; mosi_known = 1'b0;
            end else if (spi_mode != 2'b10) begin
              p++;
              if (p == 2 * WIDTH * f_h) begin
                ph = M_DONE; e_md = f_exp; e_sclk = f_cpol; mosi_known = 1'b0;
              end
            end
          end
          M_DONE: begin
            ph = M_IDLE; e_sclk = cpol;
          end
          default: ph = M_IDLE;
        endcase
        if (ph == M_LOAD || ph == M_XFER) begin
          m_e    = p / f_h;
          e_sclk = f_cpol ^ (m_e % 2 != 0);
          m_idx  = f_cpha ? ((m_e >= 3) ? (m_e - 1) / 2 : 0) : m_e / 2;
          e_mosi = f_lsb ? f_data[m_idx] : f_data[WIDTH-1-m_idx];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_en) begin
        check("ss", 32'(ss), 32'(!(ph == M_LOAD || ph == M_XFER)));
        check("tip", 32'(tip), 32'(ph == M_LOAD || ph == M_XFER));
        check("sclk", 32'(sclk), 32'(e_sclk));
        check("receive_data", 32'(receive_data), 32'(ph == M_DONE));
        check("miso_data", 32'(miso_data), 32'(e_md));
        if (mosi_known) check("mosi", 32'(mosi), 32'(e_mosi));
      end
    end
  end

  // Bench slave: shifts slave_byte out on the same edges the master shifts its own data.
  initial begin
    int n, idx;
    logic prev;
    n = 0; prev = 1'b0; slv_bit = 1'b0;
    forever begin
      @(negedge PCLK);
      if (ss) n = 0;
      else if (sclk != prev) n++;
      prev = sclk;
      idx = cpha ? ((n >= 3) ? (n - 1) / 2 : 0) : n / 2;
      if (idx > WIDTH - 1) idx = WIDTH - 1;
      slv_bit = lsbfe ? slave_byte[idx] : slave_byte[WIDTH-1-idx];
    end
  end

  task automatic wait_frame(input int h, input logic cp, output int tipc, output int edges,
                            output int bad, output logic [WIDTH-1:0] col, output int ncol,
                            output logic to);
    logic ps, pt;
    int run;
    tipc = 0; edges = 0; bad = 0; col = '0; ncol = 0; to = 1'b1;
    ps = sclk; pt = 1'b0; run = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge PCLK);
      if (pt) begin
        run++;
        if (sclk != ps) begin
          if (edges > 0 && h > 0 && run != h) bad++;
          edges++;
          run = 0;
          if (tip && sclk != cp) begin
            col = {col[WIDTH-2:0], mosi};
            ncol++;
          end
        end
      end
      if (tip) tipc++;
      ps = sclk;
      pt = tip;
      if (receive_data) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tipc, edges, bad, ncol, rdc, gap, gap_meas, npulse;
    logic [WIDTH-1:0] col;
    logic to;
    logic seen_low;

    errors = 0; checks = 0; chk_en = 1'b0;
    PRESETn = 1'b0; mstr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    sppr = 3'd0; spr = 3'd0; spi_mode = 2'b00; send_data = 1'b0; mosi_data = '0;
    loop_en = 1'b1; slave_byte = '0;

    @(posedge PCLK); #2;
    chk_en = 1'b1;
    step(2);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_tip", 32'(tip), 32'd0);
    check("rst_miso_data", 32'(miso_data), 32'd0);
    step(1);

    // Mode 0, MSB first, H=1, loopback
    mosi_data = 8'hA5; send_data = 1'b1;
    step(1);
    send_data = 1'b0;
    wait_frame(1, 1'b0, tipc, edges, bad, col, ncol, to);
    check("m0_done", 32'(to), 32'd0);
    check("m0_tip_cycles", 32'(tipc), 32'd17);
    check("m0_edges", 32'(edges), 32'd16);
    check("m0_edge_spacing", 32'(bad), 32'd0);
    check("m0_mosi_bits", 32'(col), 32'hA5);
    check("m0_mosi_count", 32'(ncol), 32'd8);
    check("m0_miso_data", 32'(miso_data), 32'hA5);
    step(2);

    // cpol=1, cpha=1, LSB first, D=12 (H=6), slave returns 0x3C
    cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; sppr = 3'd2; spr = 3'd1;
    loop_en = 1'b0; slave_byte = 8'h3C; mosi_data = 8'h0F;
    step(2);
    @(negedge PCLK);
    check("m3_sclk_idle_high", 32'(sclk), 32'd1);
    send_data = 1'b1;
    step(1);
    send_data = 1'b0;
    wait_frame(6, 1'b1, tipc, edges, bad, col, ncol, to);
    check("m3_done", 32'(to), 32'd0);
    check("m3_tip_cycles", 32'(tipc), 32'd97);
    check("m3_edges", 32'(edges), 32'd16);
    check("m3_level_len", 32'(bad), 32'd0);
    check("m3_mosi_lsb_first", 32'(col), 32'hF0);
    check("m3_miso_data", 32'(miso_data), 32'h3C);
    step(2);

    // Stop mode for 20 cycles right after edge 5, H=2
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd1; loop_en = 1'b1;
    step(2);
    mosi_data = 8'h5A; send_data = 1'b1;
    step(1);
    send_data = 1'b0;
    fork
      wait_frame(0, 1'b0, tipc, edges, bad, col, ncol, to);
      begin
        step(11);
        spi_mode = 2'b10;
        step(20);
        spi_mode = 2'b00;
      end
    join
    check("stop_done", 32'(to), 32'd0);
    check("stop_tip_cycles", 32'(tipc), 32'd53);
    check("stop_edges", 32'(edges), 32'd16);
    check("stop_mosi_bits", 32'(col), 32'h5A);
    check("stop_miso_data", 32'(miso_data), 32'h5A);
    step(2);

    // Abort after edge 7, H=1
    spr = 3'd0;
    step(1);
    mosi_data = 8'h33; send_data = 1'b1;
    step(1);
    send_data = 1'b0;
    step(8);
    mstr = 1'b0;
    step(1);
    @(negedge PCLK);
    check("abort_ss", 32'(ss), 32'd1);
    check("abort_tip", 32'(tip), 32'd0);
    rdc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (receive_data) rdc++;
    end
    check("abort_no_pulse", 32'(rdc), 32'd0);
    check("abort_miso_hold", 32'(miso_data), 32'h5A);
    mstr = 1'b1;
    step(2);

    // Reset mid-frame, held for 3 cycles
    cpol = 1'b1;
    step(2);
    mosi_data = 8'hFF; send_data = 1'b1;
    step(1);
    send_data = 1'b0;
    step(5);
    PRESETn = 1'b0;
    step(1);
    @(negedge PCLK);
    check("mrst_sclk", 32'(sclk), 32'd0);
    check("mrst_mosi", 32'(mosi), 32'd0);
    check("mrst_ss", 32'(ss), 32'd1);
    check("mrst_tip", 32'(tip), 32'd0);
    check("mrst_receive_data", 32'(receive_data), 32'd0);
    check("mrst_miso_data", 32'(miso_data), 32'd0);
    step(2);
    PRESETn = 1'b1;
    cpol = 1'b0;
    step(3);

    // Back-to-back frames with send_data held high
    mosi_data = 8'h81; send_data = 1'b1;
    seen_low = 1'b0; gap = 0; gap_meas = -1; npulse = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge PCLK);
      if (!ss) begin
        if (seen_low && gap > 0) gap_meas = gap;
        gap = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        gap++;
      end
      if (receive_data) begin
        npulse++;
        check("b2b_miso_data", 32'(miso_data), 32'h81);
        if (npulse == 2) begin
          send_data = 1'b0;
          break;
        end
      end
    end
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_ss_gap", 32'(gap_meas), 32'd2);
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
